// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register and its skid slices.
package pipe_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SLICE_EMPTY = 2'd0,
        SLICE_FULL  = 2'd1,
        SLICE_SKID  = 2'd2
    } slice_state_e;

    // Bits needed to count 0 .. 2*depth held entries.
    function automatic int occ_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// One full-throughput skid slice: a main register plus a skid register, with a
// three-state controller. in_ready depends only on registered state.
module pipe_skid_slice
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output slice_state_e      state_o
);

    slice_state_e      state_q;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;

    // Handshake: a word moves across a boundary on an edge where valid and
    // ready are both high; valid may not depend on ready, and a held valid
    // keeps its data unchanged until it is taken.
    assign in_ready  = (state_q != SLICE_SKID);
    assign out_valid = (state_q != SLICE_EMPTY);
    assign out_data  = main_data_q;
    assign state_o   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SLICE_EMPTY;
            main_data_q <= RST_DATA;
            skid_data_q <= RST_DATA;
        end else if (flush) begin
            state_q <= SLICE_EMPTY;
        end else begin
            case (state_q)
                SLICE_EMPTY: begin
                    if (in_valid) begin
                        state_q     <= SLICE_FULL;
                        main_data_q <= in_data;
                    end
                end
                SLICE_FULL: begin
                    if (in_valid && out_ready) begin
                        main_data_q <= in_data;
                    end else if (in_valid) begin
                        state_q     <= SLICE_SKID;
                        skid_data_q <= in_data;
                    end else if (out_ready) begin
                        state_q <= SLICE_EMPTY;
                    end
                end
                SLICE_SKID: begin
                    // Upstream is stalled here, so only the drain side can move.
                    if (out_ready) begin
                        state_q     <= SLICE_FULL;
                        main_data_q <= skid_data_q;
                    end
                end
                default: state_q <= SLICE_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register: DEPTH cascaded skid slices with flush fan-out.
// Define PIPE_REG_OCCUPANCY_EN to add the held-entry occupancy counter output.
module pipe_reg_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [STATE_W*DEPTH-1:0]   dbg_state
`ifdef PIPE_REG_OCCUPANCY_EN
    ,
    output logic [occ_w(DEPTH)-1:0]    occupancy
`endif
);

    // Boundary k sits in front of slice k; boundary DEPTH is the block output.
    logic              ch_valid [0:DEPTH];
    logic              ch_ready [0:DEPTH];
    logic [DATA_W-1:0] ch_data  [0:DEPTH];

    assign ch_valid[0]     = in_valid;
    assign ch_data[0]      = in_data;
    assign ch_ready[DEPTH] = out_ready;
    assign in_ready        = ch_ready[0];
    assign out_valid       = ch_valid[DEPTH];
    assign out_data        = ch_data[DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        slice_state_e st;

        pipe_skid_slice #(
            .DATA_W   (DATA_W),
            .RST_DATA (RST_DATA)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (ch_valid[k]),
            .in_ready  (ch_ready[k]),
            .in_data   (ch_data[k]),
            .out_valid (ch_valid[k+1]),
            .out_ready (ch_ready[k+1]),
            .out_data  (ch_data[k+1]),
            .state_o   (st)
        );

        assign dbg_state[STATE_W*k +: STATE_W] = st;
    end

`ifdef PIPE_REG_OCCUPANCY_EN
    localparam int OW = occ_w(DEPTH);

    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OW'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: doc/pipe_reg_hs.md
Name: pipe_reg_hs

Overview:
Parametrised, elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V core.
- Carries one packed payload of arbitrary width through DEPTH register slices.
- Uses a valid/ready handshake, a synchronous flush and full-throughput skid buffering.
- Replaces the fixed, free-running stage registers: every payload bit propagates, with backpressure and flush built in.

Parameters:
DATA_W, 32, payload width in bits (≥1); the instantiating stage packs its control and data fields.
DEPTH, 1, number of cascaded slices (≥1); sets the no-stall latency in cycles.
RST_DATA, 0, value of DATA_W bits loaded into all data registers on reset.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous flush; drops all held entries.
in_valid  in  1  upstream payload valid.
in_ready  out  1  block can accept a payload this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  downstream payload valid.
out_ready  in  1  downstream accepts a payload this cycle.
out_data  out  DATA_W  downstream payload.

Behaviour:
- Slice chaining:
  - Slice k in = slice k-1 out; slice 0 in = block input; slice DEPTH-1 out = block output.
- Per-slice registers: main_valid, main_data, skid_valid, skid_data.
  - out_valid = main_valid.
  - out_data = main_data.
  - in_ready = !skid_valid, registered-source only; no combinational path from out_ready to in_ready.
- Slice state machine (EMPTY = !main_valid; FULL = main_valid & !skid_valid; SKID = both valid):
  - EMPTY: in_valid -> FULL, main_data <= in_data.
  - FULL, in_valid & out_ready: stay FULL, main_data <= in_data.
  - FULL, in_valid & !out_ready: -> SKID, skid_data <= in_data.
  - FULL, !in_valid & out_ready: -> EMPTY.
  - FULL, otherwise: hold.
  - SKID, out_ready: -> FULL, main_data <= skid_data.
  - SKID, otherwise: hold; in_ready = 0, no input accepted.
- Transfer rule: an input transfer occurs iff in_valid & in_ready; an output transfer occurs iff out_valid & out_ready.
- Latency and capacity:
  - No backpressure: latency DEPTH cycles, throughput 1 payload/cycle.
  - Capacity 2*DEPTH entries.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged.
- Ordering: strict FIFO; no loss or duplication.
- Flush:
  - Next edge clears every main_valid and skid_valid.
  - An input accepted in the flush cycle is discarded.
  - Flush dominates all transitions.
  - Data registers need not clear.
  - in_ready is 1 the cycle after a flush.
- Reset (async assert, any time including mid-transfer):
  - All valids 0, all data = RST_DATA.
  - Outputs: out_valid 0, out_data RST_DATA, in_ready 1.
  - Reset deassertion is synchronised externally.
- No initial blocks; reset is the only initialisation.

Optional Feature:
PIPE_REG_OCCUPANCY_EN.
- When defined: adds output occupancy, width $clog2(2*DEPTH+1).
  - Counts held entries: +1 per input transfer, -1 per output transfer, net 0 when both occur.
  - Cleared to 0 by flush or reset.
  - Never exceeds 2*DEPTH.
- When undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - enum slice_state_e {SLICE_EMPTY, SLICE_FULL, SLICE_SKID}.
  - Function occ_w(depth) returning the occupancy width.
- One natural sub-module: pipe_skid_slice (DATA_W, RST_DATA), holding one slice's registers and state machine, instantiated DEPTH times via generate.
- The top level holds chaining, flush fan-out and the optional counter.

Test Plan:
1. DEPTH=1, out_ready=1: stream in_data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, in_ready stays 1.
2. DEPTH=3, out_ready=1: single 0xDEADBEEF -> out_valid asserted exactly 3 cycles after acceptance.
3. DEPTH=1, out_ready=0: offer 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted, in_ready=0 from the cycle after 0xA2; out_ready=1 -> 0xA1,0xA2,0xA3 delivered in order, no gaps.
4. DEPTH=2, two entries held, flush=1 with in_valid=1, in_data=0x55 -> next cycle out_valid=0, in_ready=1, 0x55 never appears; occupancy=0 if enabled.
5. rst_n pulled low mid-stream with DEPTH=2 full -> immediately out_valid=0, out_data=RST_DATA, in_ready=1; after release, new payload 0x77 emerges after 2 cycles.
6. PIPE_REG_OCCUPANCY_EN, DEPTH=2, out_ready=0: offer 5 payloads -> occupancy 1,2,3,4 then saturates at 4 with in_ready=0; simultaneous in/out transfer leaves the count unchanged.
